// File: rtl/fp_op_scheduler_pkg.sv
// Shared types for the FP opcode scheduler: opcode width, NOP encoding and
// dispatch FSM state encoding.
package fp_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/fp_op_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. Grants only while en is high; the pointer
// moves only when a grant is actually issued.
module rr_arb2 (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // set when A won the last grant, so B is favoured on the next contention
    logic last_a;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = !last_a;
                gnt_b = last_a;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_a <= 1'b0;
        end else if (gnt_a || gnt_b) begin
            last_a <= gnt_a;
        end
    end

endmodule

// File: rtl/fp_op_scheduler.sv
// Front end for fifobuff plus an FP execute unit: arbitrates two requesters onto
// the FIFO write port, tracks occupancy, and dispatches one opcode at a time.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | nothing in flight; leave as soon as the FIFO holds an entry
// S_POP   | fifo_read high for this single cycle
// S_LOAD  | FIFO head valid; capture into fpu_opcode, drop NOPs here
// S_ISSUE | fpu_start high for this single cycle
// S_WAIT  | opcode held at the FPU until fpu_done
module fp_op_scheduler #(
    parameter  int DEPTH = 8,
    parameter  int OP_W  = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req_a,
    input  logic [OP_W-1:0]  op_a,
    input  logic             req_b,
    input  logic [OP_W-1:0]  op_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             fifo_write,
    output logic [OP_W-1:0]  fifo_opcode_in,
    output logic             fifo_read,
    input  logic [OP_W-1:0]  fifo_opcode_out,
    output logic             fpu_start,
    output logic [OP_W-1:0]  fpu_opcode,
    input  logic             fpu_done,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    import fp_pkg::*;

    sched_state_t state, state_nxt;
    logic         grant;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign grant = gnt_a || gnt_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (!full),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fifo_write     <= 1'b0;
            fifo_opcode_in <= '0;
        end else begin
            fifo_write <= grant;
            if (gnt_a) begin
                fifo_opcode_in <= op_a;
            end else if (gnt_b) begin
                fifo_opcode_in <= op_b;
            end
        end
    end

    // count includes entries reserved by a grant whose write is still one cycle away
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else begin
            case ({grant, fifo_read})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (count != '0) state_nxt = S_POP;
            S_POP:   state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (fifo_opcode_out == OP_W'(OP_NOP)) ? S_IDLE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (fpu_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            fpu_opcode <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD) begin
                fpu_opcode <= fifo_opcode_out;
            end
        end
    end

    assign fifo_read = (state == S_POP);
    assign fpu_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Directed bench for fp_op_scheduler with a behavioural fifobuff and FPU.
module tb_fp_op_scheduler;

    localparam int DEPTH = 8;
    localparam int OP_W  = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             n_rst;
    logic             req_a, req_b;
    logic [OP_W-1:0]  op_a, op_b;
    logic             gnt_a, gnt_b;
    logic             fifo_write;
    logic [OP_W-1:0]  fifo_opcode_in;
    logic             fifo_read;
    logic [OP_W-1:0]  fifo_opcode_out;
    logic             fpu_start;
    logic [OP_W-1:0]  fpu_opcode;
    logic             fpu_done;
    logic [CNT_W-1:0] count;
    logic             full, empty, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OP_W-1:0] fq[$];
    logic [OP_W-1:0] start_q[$];
    int              start_t[$];
    int              fpu_lat   = 3;
    bit              fpu_stall = 1'b0;
    int              fpu_timer = 0;

    fp_op_scheduler #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .req_a           (req_a),
        .op_a            (op_a),
        .req_b           (req_b),
        .op_b            (op_b),
        .gnt_a           (gnt_a),
        .gnt_b           (gnt_b),
        .fifo_write      (fifo_write),
        .fifo_opcode_in  (fifo_opcode_in),
        .fifo_read       (fifo_read),
        .fifo_opcode_out (fifo_opcode_out),
        .fpu_start       (fpu_start),
        .fpu_opcode      (fpu_opcode),
        .fpu_done        (fpu_done),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fifobuff: head registered on the edge that samples the read strobe
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fq.delete();
            fifo_opcode_out <= '0;
        end else begin
            if (fifo_read && fq.size() > 0) fifo_opcode_out <= fq.pop_front();
            if (fifo_write) fq.push_back(fifo_opcode_in);
        end
    end

    // FPU: done pulses fpu_lat cycles after the start cycle, frozen while stalled
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fpu_timer = 0;
            fpu_done  = 1'b0;
        end else begin
            if (fpu_start) begin
                start_q.push_back(fpu_opcode);
                start_t.push_back(int'($time / 10));
                fpu_timer = fpu_lat;
            end else if (fpu_timer > 0 && !fpu_stall) begin
                fpu_timer--;
            end
            #1 fpu_done = (fpu_timer == 1) && !fpu_stall;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a     = 1'b0;
        req_b     = 1'b0;
        fpu_stall = 1'b0;
        n_rst     = 1'b0;
        #3;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic wait_starts(input int n, input int bound);
        for (int i = 0; i < bound && start_q.size() < n; i++) tick();
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
    endtask

    logic [OP_W-1:0] ops4 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
    logic [1:0]      exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [OP_W-1:0] exp_op3 [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

    initial begin
        int idx;
        int ng;
        int waited;
        bit seen;
        logic [1:0] g;

        n_rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        op_a  = '0;   op_b  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_fifo_write", fifo_write, 0);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_fpu_start", fpu_start, 0);
        check("rst_fpu_opcode", fpu_opcode, 0);
        #10;
        n_rst = 1'b1;
        tick();

        // single op latency chain
        req_a = 1'b1; op_a = 3'b001;
        #1;
        check("single_gnt_a", gnt_a, 1);
        tick();
        req_a = 1'b0;
        check("single_write", fifo_write, 1);
        check("single_wdata", fifo_opcode_in, 3'b001);
        check("single_count", count, 1);
        check("single_read_early", fifo_read, 0);
        tick();
        check("single_read", fifo_read, 1);
        check("single_write_drop", fifo_write, 0);
        tick();
        check("single_load_busy", busy, 1);
        check("single_load_start", fpu_start, 0);
        check("single_count_pop", count, 0);
        tick();
        check("single_start", fpu_start, 1);
        check("single_opcode", fpu_opcode, 3'b001);
        tick();
        check("single_start_pulse", fpu_start, 0);
        wait_idle(20);
        check("single_done_idle", busy, 0);
        check("single_nstart", start_q.size(), 1);

        // contention: alternating grants from a fresh pointer
        do_reset();
        start_q.delete(); start_t.delete();
        fpu_lat = 1;
        req_a = 1'b1; req_b = 1'b1; op_a = 3'b010; op_b = 3'b100;
        for (int i = 0; i < 4; i++) begin
            #1;
            g = {gnt_b, gnt_a};
            check("contend_gnt", g, exp_g[i]);
            tick();
        end
        req_a = 1'b0; req_b = 1'b0;
        wait_starts(4, 100);
        check("contend_nstart", start_q.size(), 4);
        for (int i = 0; i < 4 && i < start_q.size(); i++) check("contend_op", start_q[i], exp_op3[i]);
        if (start_t.size() >= 3) begin
            check("contend_gap01", start_t[1] - start_t[0], 5);
            check("contend_gap12", start_t[2] - start_t[1], 5);
        end
        wait_idle(20);

        // NOP is dropped without a start
        start_q.delete();
        fpu_lat = 2;
        req_a = 1'b1; op_a = 3'b000;
        tick();
        op_a = 3'b110;
        tick();
        req_a = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("nop_nstart", start_q.size(), 1);
        if (start_q.size() > 0) check("nop_op", start_q[0], 3'b110);
        check("nop_idle", busy, 0);

        // full: stalled FPU, ten ops offered
        start_q.delete();
        fpu_stall = 1'b1;
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            req_a = (idx < 10);
            op_a  = ops4[idx < 10 ? idx : 9];
            #1;
            seen = gnt_a;
            tick();
            if (seen) idx++;
        end
        check("full_accepted", idx, 9);
        check("full_count", count, DEPTH);
        check("full_flag", full, 1);
        check("full_empty", empty, 0);
        ng = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (gnt_a) ng++;
            tick();
        end
        check("full_no_gnt", ng, 0);
        check("full_count_hold", count, DEPTH);
        fpu_stall = 1'b0;
        seen = 1'b0;
        waited = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            seen = gnt_a;
            tick();
            if (seen) idx++;
            else waited++;
        end
        check("full_regrant", seen, 1);
        req_a = 1'b0;
        wait_starts(10, 300);
        check("full_nstart", start_q.size(), 10);
        for (int i = 0; i < 10 && i < start_q.size(); i++) check("full_order", start_q[i], ops4[i]);
        wait_idle(20);

        // simultaneous grant and pop at count 3
        fpu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a = 1'b1; op_a = 3'd7;
            tick();
        end
        req_a = 1'b0;
        tick();
        check("simul_pre_count", count, 3);
        fpu_stall = 1'b0;
        for (int i = 0; i < 20 && !fifo_read; i++) tick();
        check("simul_read_seen", fifo_read, 1);
        req_b = 1'b1; op_b = 3'd5;
        #1;
        check("simul_gnt_b", gnt_b, 1);
        check("simul_count_before", count, 3);
        tick();
        req_b = 1'b0;
        check("simul_count_after", count, 3);

        // asynchronous reset in the middle of WAIT
        do_reset();
        start_q.delete();
        fpu_stall = 1'b1;
        req_a = 1'b1; op_a = 3'd3;
        tick();
        op_a = 3'd5;
        tick();
        req_a = 1'b0;
        wait_starts(1, 20);
        tick();
        tick();
        check("mid_wait_busy", busy, 1);
        check("mid_wait_count", count, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_start", fpu_start, 0);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        #2;
        n_rst = 1'b1;
        fpu_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fifo_read || busy) seen = 1'b1;
        end
        check("arst_stays_idle", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
